// File: rtl/uart_rx_monitor.sv
// -----------------------------------------------------------------------------
// uart_rx_monitor
//   Oversampling UART receiver for the platform UART output line. It runs on
//   the system clock, deserialises 8-bit frames (8N1 by default) into a small
//   first-word-fall-through FIFO behind a valid/ready port, pulses frame_err on
//   a bad frame, and keeps two sticky flags: overflow (a byte was dropped
//   because the FIFO was full) and sim_end (the END_BYTE marker was received).
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   : frames are 8E1; a PARITY state sits between DATA and STOP and
//                 a parity mismatch discards the byte with a frame_err pulse.
//     undefined : 8N1 only, no parity state or logic.
//
//   Assumes FIFO_DEPTH is a power of two >= 2 and OVERSAMPLE >= 8.
// -----------------------------------------------------------------------------
module uart_rx_monitor #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  END_BYTE   = 8'h04
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  output logic                          sim_end
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // Clocks per oversampling tick, truncated (50 MHz / 115200 / 16 -> 27).
  localparam int unsigned DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  // Start bit is checked at its middle: the (OVERSAMPLE/2)-th tick after the edge.
  localparam logic [OS_W-1:0]  HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
  // Every later bit is sampled one full bit period after the previous sample.
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_WAIT_IDLE
  } state_e;
`endif

  // Line synchroniser and edge detect
  logic             rxd_meta_q;
  logic             rxd_sync_q;
  logic             rxd_prev_q;
  logic             rxd_fall;

  // Oversampling tick generator
  logic [DIV_W-1:0] div_cnt_q;
  logic             tick;

  // Frame FSM
  state_e           state_q;
  logic [OS_W-1:0]  tick_cnt_q;
  logic [OS_W-1:0]  tick_cnt_inc;
  logic             bit_sample;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             frame_ok;
  logic             push_q;
  logic             frame_err_q;
  logic             sim_end_q;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad_q;
`endif

  // Byte FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q,  rx_data_d;
  logic             overflow_q, overflow_d;
  logic             fifo_full;
  logic             do_push;
  logic             do_pop;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser plus one history flop for falling-edge detection.
  // All flops reset to the idle-high line level so reset never looks like a
  // start edge.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always written with non-blocking '<=' so every flop
  // samples the pre-edge value of its neighbours, regardless of block order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign rxd_fall = rxd_prev_q & ~rxd_sync_q;

  // ---------------------------------------------------------------------------
  // Tick generator: held at zero while idle, so the phase is cleared on the
  // IDLE->START transition and the first tick lands DIV clocks after it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) || tick) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_q + DIV_W'(1);
    end
  end

  assign tick         = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
  assign tick_cnt_inc = (tick_cnt_q == OS_LAST) ? '0 : tick_cnt_q + OS_W'(1);
  assign bit_sample   = tick && (tick_cnt_q == OS_LAST);

`ifdef UART_RX_PARITY_EN
  assign frame_ok = rxd_sync_q & ~parity_bad_q;
`else
  assign frame_ok = rxd_sync_q;
`endif

  // ---------------------------------------------------------------------------
  // Frame FSM: start-bit qualification, LSB-first data capture, optional
  // parity check, stop-bit check. A good frame raises push_q for one cycle;
  // the FIFO takes shift_q on the following edge (shift_q is stable until the
  // next frame's data bits, which are many ticks away).
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      sim_end_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          tick_cnt_q <= '0;
          if (rxd_fall) begin
            state_q <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (tick_cnt_q == HALF_LAST) begin
              // Mid start bit: a line that is high again was only a glitch.
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
              state_q    <= rxd_sync_q ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_q <= tick_cnt_q + OS_W'(1);
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_inc;
          end
          if (bit_sample) begin
            shift_q   <= {rxd_sync_q, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_inc;
          end
          if (bit_sample) begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            parity_bad_q <= rxd_sync_q ^ (^shift_q);
            state_q      <= ST_STOP;
          end
        end
`endif

        ST_STOP: begin
          if (tick) begin
            tick_cnt_q <= tick_cnt_inc;
          end
          if (bit_sample) begin
            if (frame_ok) begin
              push_q  <= 1'b1;
              state_q <= ST_IDLE;
              // The marker counts even if the FIFO later drops the byte.
              if (shift_q == END_BYTE) begin
                sim_end_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;
            end
          end
        end

        ST_WAIT_IDLE: begin
          // A held-low line (break) must go high before a new start is seen.
          if (rxd_sync_q) begin
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO next-state: push/pop arbitration, occupancy, registered head byte.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    fifo_full  = (count_q == FULL_CNT);
    do_pop     = rx_valid_q & rx_ready;
    do_push    = push_q & (~fifo_full | do_pop);
    overflow_d = overflow_q | (push_q & fifo_full & ~do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rx_data_d  = rx_data_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end

    // Head byte: the next stored entry after a pop, or the incoming byte when
    // it lands in an empty (or just-emptied) FIFO.
    if (do_pop) begin
      if (count_q > CNT_W'(1)) begin
        rx_data_d = mem_q[rd_ptr_q + PTR_W'(1)];
      end else if (do_push) begin
        rx_data_d = shift_q;
      end
    end else if ((count_q == '0) && do_push) begin
      rx_data_d = shift_q;
    end

    rx_valid_d = (count_d != '0);
  end

  // FIFO control registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage write port
  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;
  assign sim_end    = sim_end_q;

endmodule
